exec_sequencer: RTL
===================

Name: exec_sequencer

Overview:
- Multi-cycle fetch/execute/writeback controller for the 16-bit, 8-register core.
- Sits directly downstream of the register file.
  - Drives the two read addresses and consumes both read data buses and the R7 (PC) bus.
  - Feeds results back through the single write port.
- Fetches from instruction memory over a req/ack handshake.
- Performs all PC updates by writing R7.

Parameters:
- PC_INC, 1, amount added to PC for sequential flow.
- IMM_W, 6, width of the signed immediate for ADDI/BEQZ.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- imem_req  out  1  instruction fetch request
- imem_addr  out  16  fetch address (= pcout while requesting)
- imem_ack  in  1  fetch data valid this cycle
- imem_data  in  16  instruction word
- pcout  in  16  R7 value from register file
- outaddr1  out  3  read address A (ir[8:6])
- outaddr2  out  3  read address B (ir[5:3])
- out1  in  16  read data A
- out2  in  16  read data B
- regen  out  1  write enable
- inaddr  out  3  write address
- wdata  out  16  write data
- retired  out  1  one-cycle pulse per completed instruction
- illegal  out  1  one-cycle pulse on an undefined opcode
- halted  out  1  high while in HALT

Behaviour:
- Reset values: every output 0; state IDLE; ir cleared.
- Reset mid-fetch: abandons the request; a late imem_ack is ignored.
- States and transitions:
  - IDLE (1 cycle) -> FETCH.
  - FETCH: imem_req=1, imem_addr=pcout. On imem_ack, latch ir <= imem_data and go to EXEC. imem_ack outside FETCH is ignored.
  - EXEC: outaddr1/outaddr2 are driven from ir; regfile reads are combinational. Compute and register wdata/inaddr/regen, then:
    - WB if the opcode writes rd;
    - otherwise PCUPD.
  - WB: regen=1, inaddr=rd, wdata=result. Next is PCUPD, except rd==7 (jump via write): then retired=1 and go to FETCH.
  - PCUPD: regen=1, inaddr=7, wdata=next PC; retired=1; go to FETCH.
  - HALT: absorbing until rst; halted=1; no writes.
- regen is asserted only in WB and PCUPD.
- Latency: a register-writing instruction takes fetch wait + 3 cycles; a non-writing instruction takes fetch wait + 2 cycles.
- Encoding: op=ir[15:12], rd=ir[11:9], rs1=ir[8:6], rs2=ir[5:3], imm6=ir[5:0], imm9=ir[8:0].
- Opcodes:
  - 0 NOP
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR (rd = rs1 op rs2)
  - 6 SHL: rs1 << rs2[3:0]
  - 7 SHR (logical): rs1 >> rs2[3:0]
  - 8 ADDI: rd = rs1 + sext(imm6)
  - 9 LDI: rd = zext(imm9)
  - A BEQZ: if rs1==0, PC = PC+PC_INC+sext(imm6)
  - B JMP: PC = rs1
  - F HALT: next state HALT, no PC update, retired=1.
- Arithmetic: all modulo 2^16; carries and overflow discarded; PC wraps at 0xFFFF -> 0x0000.
- Undefined opcodes (C–E): executed as NOP, plus illegal pulse in EXEC.
- R0 is an ordinary register; it is not hardwired to zero.

Optional Feature:
- Macro: EXEC_MUL_EN.
- Defined: opcode C is MUL, rd = low 16 bits of rs1*rs2, same timing as ADD.
- Undefined: opcode C is illegal (NOP + illegal pulse).

Decomposition:
- Package exec_pkg:
  - opcode localparams OP_NOP..OP_HALT;
  - state encoding IDLE/FETCH/EXEC/WB/PCUPD/HALT;
  - field bit positions.
- Sub-module alu16: combinational; inputs op, a, b, imm; output result; includes MUL under EXEC_MUL_EN.
- The FSM stays in exec_sequencer.

Test Plan:
- Reset, then LDI R1,5 at addr 0 with ack after 2 cycles:
  - imem_addr=0 in FETCH;
  - WB writes R1=0x0005;
  - PCUPD writes R7=1;
  - one retired pulse.
- R1=0xFFFF, R2=1, ADD R3,R1,R2 -> R3=0x0000; SUB R4,R2,R1 -> R4=0x0002.
- BEQZ R0 (=0), imm6=0x3E (-2) at PC=5 -> R7=4. Same with R0=7 -> R7=6; no WB cycle.
- LDI R7,0x40 -> WB writes R7=0x0040, no PCUPD; the next imem_addr is 0x0040.
- HALT at PC=3:
  - halted=1 and stays;
  - imem_req stays 0;
  - regen stays 0;
  - rst recovers to IDLE, then fetches from 0.
- Opcode C:
  - with EXEC_MUL_EN, R1=3, R2=0x5555 -> rd=0xFFFF;
  - without it, illegal pulse, no WB, R7 increments.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared definitions for the fetch/execute/writeback sequencer: opcodes, FSM states, instruction fields.
// Latency: n/a (definitions only).
// Backpressure: n/a.
// Build option: EXEC_MUL_EN makes opcode C a multiply instead of an undefined opcode.
package exec_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_SHR  = 4'h7;
    localparam logic [3:0] OP_ADDI = 4'h8;
    localparam logic [3:0] OP_LDI  = 4'h9;
    localparam logic [3:0] OP_BEQZ = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_MUL  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Instruction field bit positions
    localparam int OP_MSB   = 15;
    localparam int OP_LSB   = 12;
    localparam int RD_MSB   = 11;
    localparam int RD_LSB   = 9;
    localparam int RS1_MSB  = 8;
    localparam int RS1_LSB  = 6;
    localparam int RS2_MSB  = 5;
    localparam int RS2_LSB  = 3;
    localparam int IMM9_MSB = 8;

    localparam logic [2:0] REG_PC = 3'd7;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        WB    = 3'd3,
        PCUPD = 3'd4,
        HALT  = 3'd5
    } state_t;

    // Opcodes whose result lands in rd (and so need a WB cycle)
    function automatic logic op_writes_rd(input logic [3:0] op);
        logic w;
        w = (op >= OP_ADD) && (op <= OP_LDI);
`ifdef EXEC_MUL_EN
        w = w || (op == OP_MUL);
`endif
        return w;
    endfunction

    // Opcodes C..E are undefined unless the multiplier claims C
    function automatic logic op_illegal(input logic [3:0] op);
        logic ill;
        ill = (op >= 4'hC) && (op <= 4'hE);
`ifdef EXEC_MUL_EN
        ill = ill && (op != OP_MUL);
`endif
        return ill;
    endfunction

endpackage

// File: rtl/alu16.sv
// 16-bit combinational ALU: op, a, b, imm[8:0] -> result (modulo 2^16).
// Latency: combinational, zero cycles.
// Backpressure: none; the result is consumed in the same cycle.
// Build option: EXEC_MUL_EN adds MUL on opcode C (low 16 bits of a*b).
module alu16
    import exec_pkg::*;
#(
    parameter int IMM_W = 6
) (
    input  logic [3:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [8:0]  imm,
    output logic [15:0] result
);

    logic [15:0] imm_sext;
    assign imm_sext = {{(16-IMM_W){imm[IMM_W-1]}}, imm[IMM_W-1:0]};

`ifdef EXEC_MUL_EN
    logic [31:0] prod;
    assign prod = a * b;
`endif

    always_comb begin
        result = 16'h0000;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SHL:  result = a << b[3:0];
            OP_SHR:  result = a >> b[3:0];
            OP_ADDI: result = a + imm_sext;
            OP_LDI:  result = {7'd0, imm};
`ifdef EXEC_MUL_EN
            OP_MUL:  result = prod[15:0];
`endif
            default: result = 16'h0000;
        endcase
    end

endmodule

// File: rtl/exec_sequencer.sv
// Fetch/execute/writeback controller for the 16-bit 8-register core; all PC updates go through R7 writes.
// Latency: fetch wait + 3 cycles for rd-writing ops, fetch wait + 2 otherwise (rd==7 writes skip PCUPD).
// Backpressure: fetch stalls in FETCH until imem_ack; ack outside FETCH is ignored.
// Ports: clk/rst (sync, active-high); imem_req/addr/ack/data fetch port; pcout/out1/out2 regfile reads,
//        outaddr1/outaddr2 read addresses; regen/inaddr/wdata write port; retired/illegal pulses; halted level.
// Build option: EXEC_MUL_EN enables MUL on opcode C.
module exec_sequencer
    import exec_pkg::*;
#(
    parameter int PC_INC = 1,
    parameter int IMM_W  = 6
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    input  logic [15:0] pcout,
    output logic [2:0]  outaddr1,
    output logic [2:0]  outaddr2,
    input  logic [15:0] out1,
    input  logic [15:0] out2,
    output logic        regen,
    output logic [2:0]  inaddr,
    output logic [15:0] wdata,
    output logic        retired,
    output logic        illegal,
    output logic        halted
);

    state_t      state, state_nx;
    logic [15:0] ir;
    logic        regen_nx;
    logic [2:0]  inaddr_nx;
    logic [15:0] wdata_nx;

    logic [3:0]  op;
    logic [2:0]  rd;
    logic [15:0] alu_res;
    logic [15:0] pc_seq;
    logic [15:0] br_off;
    logic [15:0] next_pc;

    assign op       = ir[OP_MSB:OP_LSB];
    assign rd       = ir[RD_MSB:RD_LSB];
    assign outaddr1 = ir[RS1_MSB:RS1_LSB];
    assign outaddr2 = ir[RS2_MSB:RS2_LSB];

    assign pc_seq = pcout + 16'(PC_INC);
    assign br_off = {{(16-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};

    alu16 #(.IMM_W(IMM_W)) u_alu (
        .op     (op),
        .a      (out1),
        .b      (out2),
        .imm    (ir[IMM9_MSB:0]),
        .result (alu_res)
    );

    // PC value for instructions that do not write rd
    always_comb begin
        next_pc = pc_seq;
        case (op)
            OP_BEQZ: next_pc = (out1 == 16'h0000) ? (pc_seq + br_off) : pc_seq;
            OP_JMP:  next_pc = out1;
            default: next_pc = pc_seq;
        endcase
    end

    // Write-port values are registered on entry to WB/PCUPD so they are
    // stable for the whole write cycle; the remaining outputs are decoded
    // directly from the current state.
    always_comb begin
        state_nx  = state;
        regen_nx  = 1'b0;
        inaddr_nx = 3'd0;
        wdata_nx  = 16'h0000;
        imem_req  = 1'b0;
        imem_addr = 16'h0000;
        retired   = 1'b0;
        illegal   = 1'b0;
        halted    = 1'b0;
        case (state)
            IDLE: state_nx = FETCH;
            FETCH: begin
                imem_req  = 1'b1;
                imem_addr = pcout;
                if (imem_ack) state_nx = EXEC;
            end
            EXEC: begin
                illegal = op_illegal(op);
                if (op == OP_HALT) begin
                    retired  = 1'b1;
                    state_nx = HALT;
                end else if (op_writes_rd(op)) begin
                    state_nx  = WB;
                    regen_nx  = 1'b1;
                    inaddr_nx = rd;
                    wdata_nx  = alu_res;
                end else begin
                    state_nx  = PCUPD;
                    regen_nx  = 1'b1;
                    inaddr_nx = REG_PC;
                    wdata_nx  = next_pc;
                end
            end
            WB: begin
                if (rd == REG_PC) begin
                    // The result itself is the new PC; no sequential bump.
                    retired  = 1'b1;
                    state_nx = FETCH;
                end else begin
                    // R7 is not written until PCUPD, so pcout is still the
                    // address of this instruction.
                    state_nx  = PCUPD;
                    regen_nx  = 1'b1;
                    inaddr_nx = REG_PC;
                    wdata_nx  = pc_seq;
                end
            end
            PCUPD: begin
                retired  = 1'b1;
                state_nx = FETCH;
            end
            HALT: halted = 1'b1;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ir     <= 16'h0000;
            regen  <= 1'b0;
            inaddr <= 3'd0;
            wdata  <= 16'h0000;
        end else begin
            state  <= state_nx;
            regen  <= regen_nx;
            inaddr <= inaddr_nx;
            wdata  <= wdata_nx;
            if (state == FETCH && imem_ack) ir <= imem_data;
        end
    end

endmodule
